// File: rtl/dds_cfg_scheduler_if.sv
// Write-port bundle for dds_cfg_scheduler: config request side, dispatcher
// writeback side and the shared BlockRam write port.
// slave modport = scheduler, master modport = the surrounding system.
interface dds_cfg_scheduler_if #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned FIFO_DEPTH = 4
);
    // Config front end
    logic                          cfg_valid;
    logic                          cfg_ready;
    logic [ADDR_W-1:0]             cfg_addr;
    logic [17:0]                   cfg_data;
    logic [$clog2(FIFO_DEPTH):0]   cfg_level;

    // Dispatcher writeback
    logic                          dsp_busy;
    logic                          dsp_w_en;
    logic [ADDR_W-1:0]             dsp_w_addr;
    logic [8:0]                    dsp_w_value_L;
    logic [8:0]                    dsp_w_value_H;

    // Shared RAM write port
    logic                          ram_w_en;
    logic [ADDR_W-1:0]             ram_w_addr;
    logic [8:0]                    ram_w_value_L;
    logic [8:0]                    ram_w_value_H;

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data,
        input  dsp_busy, dsp_w_en, dsp_w_addr, dsp_w_value_L, dsp_w_value_H,
        output cfg_ready, cfg_level,
        output ram_w_en, ram_w_addr, ram_w_value_L, ram_w_value_H
    );

    modport master (
        output cfg_valid, cfg_addr, cfg_data,
        output dsp_busy, dsp_w_en, dsp_w_addr, dsp_w_value_L, dsp_w_value_H,
        input  cfg_ready, cfg_level,
        input  ram_w_en, ram_w_addr, ram_w_value_L, ram_w_value_H
    );
endinterface

// File: rtl/dds_cfg_scheduler.sv
// DDS register write-port scheduler.
// Merges dispatcher writeback (always wins) with queued config writes, which
// drain one per cycle only while the dispatcher is idle. All RAM outputs are
// registered (1 cycle latency on both paths).
// Optional feature: define DDS_CFG_COALESCE_EN to merge a push into the
// youngest queued entry with the same address instead of appending.
module dds_cfg_scheduler #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    IO_main_clk,
    input  logic                    IO_rst_n,
    dds_cfg_scheduler_if.slave      bus
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);
    localparam logic [LvlW-1:0] LvlOne  = LvlW'(1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StDrain   = 2'd1,
        StBlocked = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Queue storage and bookkeeping
    logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_mem_d [FIFO_DEPTH];
    logic [17:0]       data_mem_q [FIFO_DEPTH];
    logic [17:0]       data_mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;

    // Registered RAM port
    logic              ram_w_en_q, ram_w_en_d;
    logic [ADDR_W-1:0] ram_w_addr_q, ram_w_addr_d;
    logic [8:0]        ram_w_value_l_q, ram_w_value_l_d;
    logic [8:0]        ram_w_value_h_q, ram_w_value_h_d;

    logic              full, empty, push, pop, append;
    logic              coalesce_hit;
    logic [PtrW-1:0]   coalesce_idx;

    assign full   = (level_q == LvlFull);
    assign empty  = (level_q == '0);
    // Full rejects a push even when a pop frees a slot in the same cycle.
    assign push   = bus.cfg_valid & ~full;
    assign pop    = (state_q == StDrain) & ~empty & ~bus.dsp_busy & ~bus.dsp_w_en;
    assign append = push & ~coalesce_hit;

`ifdef DDS_CFG_COALESCE_EN
    logic [PtrW-1:0] scan_idx;

    // Find the youngest queued entry matching the push address; the head being
    // popped this cycle is excluded so the new value still reaches the RAM.
    always_comb begin
        coalesce_hit = 1'b0;
        coalesce_idx = '0;
        scan_idx     = '0;
        for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
            scan_idx = rd_ptr_q + PtrW'(k);
            if ((k < 32'(level_q)) && !((k == 0) && pop) &&
                (addr_mem_q[scan_idx] == bus.cfg_addr)) begin
                coalesce_hit = 1'b1;
                coalesce_idx = scan_idx;
            end
        end
    end
`else
    assign coalesce_hit = 1'b0;
    assign coalesce_idx = '0;
`endif

    // Queue next state: append/overwrite on push, advance head on pop.
    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        if (append) begin
            addr_mem_d[wr_ptr_q] = bus.cfg_addr;
            data_mem_d[wr_ptr_q] = bus.cfg_data;
            wr_ptr_d             = wr_ptr_q + PtrW'(1);
        end
        if (push && coalesce_hit) begin
            data_mem_d[coalesce_idx] = bus.cfg_data;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({append, pop})
            2'b10:   level_d = level_q + LvlOne;
            2'b01:   level_d = level_q - LvlOne;
            default: level_d = level_q;
        endcase
    end

    // FSM next state; a same-cycle push counts as pending work.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!empty || push) begin
                    state_d = bus.dsp_busy ? StBlocked : StDrain;
                end
            end
            StDrain: begin
                if (bus.dsp_busy && !empty) begin
                    state_d = StBlocked;
                end else if (pop && (level_q == LvlOne) && !push) begin
                    state_d = StIdle;
                end else if (empty && !push) begin
                    state_d = StIdle;
                end
            end
            StBlocked: begin
                if (!bus.dsp_busy) begin
                    state_d = StDrain;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // RAM port mux: dispatcher first, then queue head; addr/data hold when idle.
    always_comb begin
        ram_w_en_d      = 1'b0;
        ram_w_addr_d    = ram_w_addr_q;
        ram_w_value_l_d = ram_w_value_l_q;
        ram_w_value_h_d = ram_w_value_h_q;
        if (bus.dsp_w_en) begin
            ram_w_en_d      = 1'b1;
            ram_w_addr_d    = bus.dsp_w_addr;
            ram_w_value_l_d = bus.dsp_w_value_L;
            ram_w_value_h_d = bus.dsp_w_value_H;
        end else if (pop) begin
            ram_w_en_d      = 1'b1;
            ram_w_addr_d    = addr_mem_q[rd_ptr_q];
            ram_w_value_l_d = data_mem_q[rd_ptr_q][8:0];
            ram_w_value_h_d = data_mem_q[rd_ptr_q][17:9];
        end
    end

    // FSM state register
    always_ff @(posedge IO_main_clk or negedge IO_rst_n) begin
        if (!IO_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Queue registers; reset discards any queued writes.
    always_ff @(posedge IO_main_clk or negedge IO_rst_n) begin
        if (!IO_rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            addr_mem_q <= addr_mem_d;
            data_mem_q <= data_mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
        end
    end

    // RAM output registers
    always_ff @(posedge IO_main_clk or negedge IO_rst_n) begin
        if (!IO_rst_n) begin
            ram_w_en_q      <= 1'b0;
            ram_w_addr_q    <= '0;
            ram_w_value_l_q <= '0;
            ram_w_value_h_q <= '0;
        end else begin
            ram_w_en_q      <= ram_w_en_d;
            ram_w_addr_q    <= ram_w_addr_d;
            ram_w_value_l_q <= ram_w_value_l_d;
            ram_w_value_h_q <= ram_w_value_h_d;
        end
    end

    assign bus.cfg_ready     = ~full;
    assign bus.cfg_level     = level_q;
    assign bus.ram_w_en      = ram_w_en_q;
    assign bus.ram_w_addr    = ram_w_addr_q;
    assign bus.ram_w_value_L = ram_w_value_l_q;
    assign bus.ram_w_value_H = ram_w_value_h_q;

endmodule

// File: tb/tb_dds_cfg_scheduler.sv
// Directed self-checking bench for dds_cfg_scheduler.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected coalescing results follow DDS_CFG_COALESCE_EN.
module tb_dds_cfg_scheduler;

    typedef struct packed {
        logic [9:0] addr;
        logic [8:0] h;
        logic [8:0] l;
    } wr_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    wr_t  wr_log[$];

    dds_cfg_scheduler_if #(.ADDR_W(10), .FIFO_DEPTH(4)) u_if ();

    dds_cfg_scheduler #(.ADDR_W(10), .FIFO_DEPTH(4)) u_dut (
        .IO_main_clk (clk),
        .IO_rst_n    (rst_n),
        .bus         (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge and log any RAM write seen there.
    task automatic tick();
        @(negedge clk);
        if (u_if.ram_w_en === 1'b1) begin
            wr_log.push_back({u_if.ram_w_addr, u_if.ram_w_value_H, u_if.ram_w_value_L});
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare logged write idx against {addr, H, L} = {a, d}.
    task automatic check_wr(input string tag, input int idx, input logic [9:0] a,
                            input logic [17:0] d);
        logic [31:0] got;
        got = (idx < wr_log.size()) ? 32'(wr_log[idx]) : 32'hFFFF_FFFF;
        check_eq(tag, got, 32'({a, d}));
    endtask

    task automatic push_cfg(input logic [9:0] a, input logic [17:0] d);
        u_if.cfg_valid = 1'b1;
        u_if.cfg_addr  = a;
        u_if.cfg_data  = d;
        tick();
        u_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while (wr_log.size() < n && i < budget) begin
            tick();
            i++;
        end
        check_eq(tag, 32'(wr_log.size()), 32'(n));
    endtask

    logic [17:0] dvec [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        dvec[0] = 18'h00001;
        dvec[1] = 18'h1FFFF;
        dvec[2] = 18'h2AAAA;
        dvec[3] = 18'h15555;

        rst_n              = 1'b0;
        u_if.cfg_valid     = 1'b1;
        u_if.cfg_addr      = 10'h007;
        u_if.cfg_data      = 18'h00155;
        u_if.dsp_busy      = 1'b0;
        u_if.dsp_w_en      = 1'b0;
        u_if.dsp_w_addr    = '0;
        u_if.dsp_w_value_L = '0;
        u_if.dsp_w_value_H = '0;

        // Reset held with a pending request
        repeat (3) tick();
        check_eq("rst_wen", 32'(u_if.ram_w_en), 32'd0);
        check_eq("rst_level", 32'(u_if.cfg_level), 32'd0);
        check_eq("rst_ready", 32'(u_if.cfg_ready), 32'd1);
        check_eq("rst_addr", 32'(u_if.ram_w_addr), 32'd0);
        u_if.cfg_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("rel_level", 32'(u_if.cfg_level), 32'd0);
        check_eq("rel_wen", 32'(u_if.ram_w_en), 32'd0);

        // Idle drain: two-cycle latency
        wr_log.delete();
        push_cfg(10'h005, 18'h2A5A5);
        check_eq("idle_lvl1", 32'(u_if.cfg_level), 32'd1);
        check_eq("idle_wen0", 32'(u_if.ram_w_en), 32'd0);
        tick();
        check_eq("idle_wen1", 32'(u_if.ram_w_en), 32'd1);
        check_eq("idle_addr", 32'(u_if.ram_w_addr), 32'h005);
        check_eq("idle_L", 32'(u_if.ram_w_value_L), 32'h1A5);
        check_eq("idle_H", 32'(u_if.ram_w_value_H), 32'h152);
        check_eq("idle_lvl0", 32'(u_if.cfg_level), 32'd0);
        tick();
        check_eq("idle_wen_end", 32'(u_if.ram_w_en), 32'd0);
        check_eq("idle_count", 32'(wr_log.size()), 32'd1);

        // Back-to-back pushes: second push coincides with first pop
        wr_log.delete();
        push_cfg(10'h011, 18'h00111);
        push_cfg(10'h012, 18'h00222);
        check_eq("pp_level", 32'(u_if.cfg_level), 32'd1);
        check_eq("pp_addr0", 32'(u_if.ram_w_addr), 32'h011);
        tick();
        check_eq("pp_addr1", 32'(u_if.ram_w_addr), 32'h012);
        check_eq("pp_lvl0", 32'(u_if.cfg_level), 32'd0);
        tick();

        // Blocked: fill queue while dispatcher busy
        wr_log.delete();
        u_if.dsp_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_cfg(10'h020 + 10'(i), dvec[i]);
        check_eq("blk_level", 32'(u_if.cfg_level), 32'd4);
        check_eq("blk_ready", 32'(u_if.cfg_ready), 32'd0);
        check_eq("blk_nowr", 32'(wr_log.size()), 32'd0);
        // Push while full is rejected; dispatcher write passes through
        u_if.cfg_valid     = 1'b1;
        u_if.cfg_addr      = 10'h3FF;
        u_if.cfg_data      = 18'h3FFFF;
        u_if.dsp_w_en      = 1'b1;
        u_if.dsp_w_addr    = 10'h100;
        u_if.dsp_w_value_L = 9'h0AB;
        u_if.dsp_w_value_H = 9'h0CD;
        tick();
        u_if.cfg_valid = 1'b0;
        u_if.dsp_w_en  = 1'b0;
        check_eq("blk_dsp_wen", 32'(u_if.ram_w_en), 32'd1);
        check_eq("blk_dsp_addr", 32'(u_if.ram_w_addr), 32'h100);
        check_eq("blk_dsp_L", 32'(u_if.ram_w_value_L), 32'h0AB);
        check_eq("blk_dsp_H", 32'(u_if.ram_w_value_H), 32'h0CD);
        check_eq("blk_full_lvl", 32'(u_if.cfg_level), 32'd4);
        tick();
        check_eq("blk_hold_wen", 32'(u_if.ram_w_en), 32'd0);
        wr_log.delete();
        u_if.dsp_busy = 1'b0;
        tick();
        check_eq("blk_unblock", 32'(u_if.ram_w_en), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("blk_consec", 32'(u_if.ram_w_en), 32'd1);
        end
        for (int i = 0; i < 4; i++) check_wr("blk_order", i, 10'h020 + 10'(i), dvec[i]);
        tick();
        check_eq("blk_done_wen", 32'(u_if.ram_w_en), 32'd0);
        check_eq("blk_done_lvl", 32'(u_if.cfg_level), 32'd0);

        // Collision during drain
        wr_log.delete();
        u_if.dsp_busy = 1'b1;
        for (int i = 0; i < 3; i++) push_cfg(10'h030 + 10'(i), dvec[i+1]);
        u_if.dsp_busy = 1'b0;
        tick();
        check_eq("col_lvl3", 32'(u_if.cfg_level), 32'd3);
        u_if.dsp_w_en      = 1'b1;
        u_if.dsp_w_addr    = 10'h010;
        u_if.dsp_w_value_L = 9'h011;
        u_if.dsp_w_value_H = 9'h022;
        tick();
        u_if.dsp_w_en = 1'b0;
        check_eq("col_hold_lvl", 32'(u_if.cfg_level), 32'd3);
        wait_writes(4, 10, "col_count");
        check_wr("col_dsp", 0, 10'h010, {9'h022, 9'h011});
        for (int i = 0; i < 3; i++) check_wr("col_cfg", i + 1, 10'h030 + 10'(i), dvec[i+1]);
        check_eq("col_lvl0", 32'(u_if.cfg_level), 32'd0);

        // Reset in the middle of a drain
        wr_log.delete();
        u_if.dsp_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_cfg(10'h040 + 10'(i), dvec[i]);
        u_if.dsp_busy = 1'b0;
        wait_writes(2, 10, "mrst_two");
        rst_n = 1'b0;
        #1;
        check_eq("mrst_wen", 32'(u_if.ram_w_en), 32'd0);
        check_eq("mrst_lvl", 32'(u_if.cfg_level), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check_eq("mrst_count", 32'(wr_log.size()), 32'd2);
        check_eq("mrst_lvl_after", 32'(u_if.cfg_level), 32'd0);
        check_wr("mrst_w1", 1, 10'h041, dvec[1]);

        // Duplicate address while blocked
        wr_log.delete();
        u_if.dsp_busy = 1'b1;
        push_cfg(10'h003, 18'd1);
        push_cfg(10'h003, 18'd2);
`ifdef DDS_CFG_COALESCE_EN
        check_eq("dup_level", 32'(u_if.cfg_level), 32'd1);
        u_if.dsp_busy = 1'b0;
        repeat (6) tick();
        check_eq("dup_count", 32'(wr_log.size()), 32'd1);
        check_wr("dup_w0", 0, 10'h003, 18'd2);
`else
        check_eq("dup_level", 32'(u_if.cfg_level), 32'd2);
        u_if.dsp_busy = 1'b0;
        repeat (6) tick();
        check_eq("dup_count", 32'(wr_log.size()), 32'd2);
        check_wr("dup_w0", 0, 10'h003, 18'd1);
        check_wr("dup_w1", 1, 10'h003, 18'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
